fir: RTL and testbench
======================

# fir

Transposed-free, direct-form TAPS-tap FIR filter on unsigned BITS-bit samples, advanced one sample per `start` pulse. It sits between a sample source and a sample sink in a tiny-silicon datapath. Each new sample is shifted into a delay line, and a registered, scaled and range-limited output `y` is produced one clock later.

## Interface
- `BITS`, default 8: sample width of `x` and `y`.
- `TAPS`, default 4: number of taps; legal range 1..16.
- `COEFF_SHIFT`, default 2: right shift applied to the accumulator before output.
- `clk` input, 1 bit: single clock, all state on rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-high. The port keeps the codebase name `rst_n`, but asserting it high resets the block.
- `start` input, 1 bit: sample strobe, sampled on the rising edge of `clk`.
- `x` input, BITS bits: new unsigned sample, valid when `start` = 1.
- `y` output, BITS bits: registered unsigned filter output.

## Operation
- Delay line `d[0..TAPS-1]`, each BITS wide.
- On an edge with `start` = 1:
  - `d[0] <= x`.
  - `d[i] <= d[i-1]` for i ≥ 1.
  - `y` is loaded from acc = C[0]·x + Σ_{i=1..TAPS-1} C[i]·d[i-1], using the pre-shift delay contents.
- Coefficients C[i] are unsigned, 8 bits each, taken from the package table. Defaults: C = 1, 3, 3, 1, then zeros.
- Accumulator width is BITS + 8 + 4 bits and never overflows for TAPS ≤ 16.
- The scaled value is s = acc >> COEFF_SHIFT (logical shift).
- Range limiting of s into BITS is set by the macro in Configuration.
- On an edge with `start` = 0: delay line and `y` hold.
- `start` held high for several consecutive cycles: one sample is consumed per cycle. No edge detection is performed.
- `x` is ignored when `start` = 0.

## Timing
- Reset, while `rst_n` = 1: all `d[i]` = 0 and `y` = 0, applied immediately and independent of `clk`.
- Reset asserted mid-stream discards all history. The first sample after release sees zero history.
- Latency: `y` reflects the sample presented with `start` on the same rising edge, visible right after that edge (1 clock).
- No busy signal. A new `start` is accepted every cycle; there is no minimum spacing.
- `y` is stable between strobes.

## Configuration
- Macro `FIR_SATURATE_EN`:
  - Defined: if s > 2^BITS − 1, then `y` = 2^BITS − 1 (unsigned clamp).
  - Undefined: `y` = s[BITS-1:0] (wrap-around truncation).
- Everything else is identical in both builds.

## Structure
- Package `fir_pkg` holds:
  - `COEFF_W` = 8.
  - `MAX_TAPS` = 16.
  - Constant coefficient table of MAX_TAPS entries.
  - Accumulator-width helper.
- Elaboration rejects TAPS > MAX_TAPS.
- One sub-module, `fir_mac`: combinational multiply-accumulate over the tap vector, producing acc. The top module owns the delay line, shift, range limiting and output register.

## Test plan
- Reset: assert `rst_n` = 1 mid-operation → `y` = 0 immediately; the next strobe with x = 0x80 → `y` = 0x20.
- Impulse: strobe x = 0x80, then 0x00 ×4 → `y` = 0x20, 0x60, 0x60, 0x20, 0x00.
- DC: strobe x = 0x40 ×4 → `y` = 0x10, 0x40, 0x70, 0x80, steady at 0x80.
- Overflow: strobe x = 0xFF ×4 → final `y` = 0xFF with `FIR_SATURATE_EN` defined, 0xFE without.
- Hold: after the DC sequence, drive `start` = 0 for 10 cycles while `x` toggles randomly → `y` and the delay line are unchanged.
- Back-to-back: `start` high for 4 consecutive cycles with x = 0x80, 0, 0, 0 → `y` follows the impulse sequence on consecutive edges.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the fir block: coefficient table and accumulator sizing.
package fir_pkg;

  localparam int unsigned COEFF_W  = 8;
  localparam int unsigned MAX_TAPS = 16;

  // Tap weights, index 0 applies to the newest sample; unused taps are zero.
  localparam logic [COEFF_W-1:0] COEFF_TABLE [MAX_TAPS] = '{
    8'd1, 8'd3, 8'd3, 8'd1,
    8'd0, 8'd0, 8'd0, 8'd0,
    8'd0, 8'd0, 8'd0, 8'd0,
    8'd0, 8'd0, 8'd0, 8'd0
  };

  // Sample width + coefficient width + log2(MAX_TAPS) guard bits.
  function automatic int unsigned acc_width(input int unsigned bits);
    return bits + COEFF_W + 4;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate over the tap vector using the package table.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned BITS  = 8,
  parameter int unsigned TAPS  = 4,
  parameter int unsigned ACC_W = acc_width(BITS)
) (
  input  logic [TAPS-1:0][BITS-1:0] i_taps,
  output logic [ACC_W-1:0]          o_acc_c
);

  logic [ACC_W-1:0] w_sum;

  // Sum of products; widened before multiplying so nothing is lost.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      w_sum = w_sum + (ACC_W'(i_taps[i]) * ACC_W'(COEFF_TABLE[i]));
    end
  end

  assign o_acc_c = w_sum;

endmodule

// File: rtl/fir.sv
// Direct-form FIR on unsigned samples, one sample consumed per start strobe.
// Optional feature macro: FIR_SATURATE_EN (clamp output instead of wrapping).
module fir
  import fir_pkg::*;
#(
  parameter int unsigned BITS        = 8,
  parameter int unsigned TAPS        = 4,
  parameter int unsigned COEFF_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] x,
  output logic [BITS-1:0] y
);

  localparam int unsigned ACC_W = acc_width(BITS);

  // Reject tap counts the coefficient table and guard bits cannot cover.
  if (TAPS < 1 || TAPS > MAX_TAPS) begin : g_bad_taps
    $error("fir: TAPS must be in 1..%0d", MAX_TAPS);
  end

  logic [TAPS-1:0][BITS-1:0] r_d;
  logic [TAPS-1:0][BITS-1:0] w_taps;
  logic [ACC_W-1:0]          w_acc;
  logic [ACC_W-1:0]          w_scaled;
  logic [BITS-1:0]           w_limited;
  logic                      w_unused_tail;

  // Newest sample feeds tap 0; older taps read the pre-shift delay line.
  always_comb begin
    w_taps    = '0;
    w_taps[0] = x;
    for (int i = 1; i < int'(TAPS); i++) begin
      w_taps[i] = r_d[i-1];
    end
  end

  // The oldest delay stage only ages out; it never feeds a product.
  assign w_unused_tail = ^r_d[TAPS-1];

  fir_mac #(
    .BITS  (BITS),
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_taps  (w_taps),
    .o_acc_c (w_acc)
  );

  assign w_scaled = w_acc >> COEFF_SHIFT;

`ifdef FIR_SATURATE_EN
  // Clamp to the largest representable sample.
  always_comb begin
    w_limited = w_scaled[BITS-1:0];
    if (w_scaled > ACC_W'({BITS{1'b1}})) begin
      w_limited = {BITS{1'b1}};
    end
  end
`else
  logic w_unused_hi;

  // Wrap-around: keep only the low BITS of the scaled value.
  always_comb begin
    w_limited = w_scaled[BITS-1:0];
  end

  assign w_unused_hi = ^w_scaled[ACC_W-1:BITS];
`endif

  // Delay line and output advance together on each strobe; reset clears history.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_d <= '0;
      y   <= '0;
    end else if (start) begin
      r_d[0] <= x;
      for (int i = 1; i < int'(TAPS); i++) begin
        r_d[i] <= r_d[i-1];
      end
      y <= w_limited;
    end
  end

endmodule

// File: tb/tb_fir.sv
// Directed, table-driven bench for fir with default parameters.
module tb_fir;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;

  int n_checks;
  int n_fail;

  typedef struct {
    string      name;
    logic       start;
    logic [7:0] x;
    logic [7:0] y_exp;
  } vec_t;

  vec_t vecs[$];

`ifdef FIR_SATURATE_EN
  localparam logic [7:0] OVF3 = 8'hFF;
  localparam logic [7:0] OVF4 = 8'hFF;
`else
  localparam logic [7:0] OVF3 = 8'hBE;
  localparam logic [7:0] OVF4 = 8'hFE;
`endif

  fir u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: y=0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic s, input logic [7:0] xv);
    @(negedge clk);
    start = s;
    x     = xv;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string nm, input logic s, input logic [7:0] xv,
                              input logic [7:0] ye);
    vec_t v;
    v.name  = nm;
    v.start = s;
    v.x     = xv;
    v.y_exp = ye;
    vecs.push_back(v);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    x        = 8'h00;
    rst_n    = 1'b1;
    #1;
    check("reset_init", y, 8'h00);

    // Impulse with idle gaps between strobes.
    add("imp0",  1'b1, 8'h80, 8'h20);
    add("imp_h", 1'b0, 8'h55, 8'h20);
    add("imp1",  1'b1, 8'h00, 8'h60);
    add("imp2",  1'b1, 8'h00, 8'h60);
    add("imp_h", 1'b0, 8'hAA, 8'h60);
    add("imp3",  1'b1, 8'h00, 8'h20);
    add("imp4",  1'b1, 8'h00, 8'h00);
    // DC step.
    add("dc0", 1'b1, 8'h40, 8'h10);
    add("dc1", 1'b1, 8'h40, 8'h40);
    add("dc2", 1'b1, 8'h40, 8'h70);
    add("dc3", 1'b1, 8'h40, 8'h80);
    add("dc4", 1'b1, 8'h40, 8'h80);
    // Hold with x toggling; next strobe proves the delay line was untouched.
    for (int i = 0; i < 10; i++) add("hold", 1'b0, 8'($urandom), 8'h80);
    add("hold_after", 1'b1, 8'h40, 8'h80);
    // Flush to zero history.
    add("flush0", 1'b1, 8'h00, 8'h70);
    add("flush1", 1'b1, 8'h00, 8'h40);
    add("flush2", 1'b1, 8'h00, 8'h10);
    add("flush3", 1'b1, 8'h00, 8'h00);
    // Full-scale input exercises range limiting.
    add("ovf1", 1'b1, 8'hFF, 8'h3F);
    add("ovf2", 1'b1, 8'hFF, 8'hFF);
    add("ovf3", 1'b1, 8'hFF, OVF3);
    add("ovf4", 1'b1, 8'hFF, OVF4);

    @(negedge clk);
    rst_n = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].x);
      check(vecs[i].name, y, vecs[i].y_exp);
    end

    // Mid-stream reset: asynchronous clear, then zero history after release.
    step(1'b1, 8'h80);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_async", y, 8'h00);
    start = 1'b1;
    x     = 8'h33;
    @(posedge clk);
    #1;
    check("rst_held", y, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    step(1'b1, 8'h80);
    check("rst_first", y, 8'h20);
    step(1'b1, 8'h00);
    check("rst_second", y, 8'h60);
    step(1'b1, 8'h00);
    check("rst_third", y, 8'h60);
    step(1'b1, 8'h00);
    check("rst_fourth", y, 8'h20);
    step(1'b1, 8'h00);
    check("rst_fifth", y, 8'h00);

    // Back-to-back: start held high, one sample per edge.
    @(negedge clk);
    start = 1'b1;
    x     = 8'h80;
    @(posedge clk);
    #1;
    check("b2b0", y, 8'h20);
    x = 8'h00;
    @(posedge clk);
    #1;
    check("b2b1", y, 8'h60);
    @(posedge clk);
    #1;
    check("b2b2", y, 8'h60);
    @(posedge clk);
    #1;
    check("b2b3", y, 8'h20);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_hold", y, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
